// File: rtl/matmul_engine_if.sv
// matmul_engine_if
//   Handshake and operand/result bus for matmul_engine.
//   Ports carried by the interface:
//     start       request a multiply (sampled only while the engine is idle)
//     accumulate  sampled with start: 1 gives C = C + A x B, 0 gives C = A x B
//     a_flat      matrix A, element (i,j) at bits [(i*N+j)*8 +: 8]
//     b_flat      matrix B, same packing
//     c_flat      registered result C, same packing
//     busy        high while the engine is running
//     done        one-cycle pulse once C is final
//     ovf         sticky saturation flag
//   master drives the request side; slave is the engine.
interface matmul_engine_if #(
   parameter int unsigned N = 3
);
   logic             start;
   logic             accumulate;
   logic [N*N*8-1:0] a_flat;
   logic [N*N*8-1:0] b_flat;
   logic [N*N*8-1:0] c_flat;
   logic             busy;
   logic             done;
   logic             ovf;

   modport master (
      output start, accumulate, a_flat, b_flat,
      input  c_flat, busy, done, ovf
   );

   modport slave (
      input  start, accumulate, a_flat, b_flat,
      output c_flat, busy, done, ovf
   );
endinterface

// File: rtl/matmul_engine.sv
// matmul_engine
//   N x N matrix multiply/accumulate over an 8-bit mini-float format
//   (sign bit7, exponent bits6:4, fraction bits3:0, 0x30 = 1.0).
//   All N*N cells are updated in a systolic wavefront: at step t a cell
//   (i,j) consumes product term k = t-i-j, so one run takes 3N-2 steps.
//   Ports:
//     clk    single clock, rising edge
//     reset  synchronous, active-high
//     bus    matmul_engine_if slave modport (start, accumulate, a_flat,
//            b_flat in; c_flat, busy, done, ovf out, all registered)
module matmul_engine #(
   parameter int unsigned N = 3
) (
   input  logic            clk,
   input  logic            reset,
   matmul_engine_if.slave  bus
);

   localparam int unsigned TW   = $clog2(3 * N - 1);
   localparam logic [TW-1:0] LAST = TW'(3 * N - 3);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t        state;
   logic [TW-1:0] t_q;
   logic          busy_q;
   logic          done_q;
   logic          ovf_q;

   logic [7:0] a_q   [N][N];
   logic [7:0] b_q   [N][N];
   logic [7:0] c_q   [N][N];
   logic [7:0] c_nxt [N][N];
   logic       sat_any;

   // Product of two mini-floats; bit 8 of the result flags saturation.
   function automatic logic [8:0] fp_mul(input logic [7:0] x, input logic [7:0] y);
      logic [4:0]  mx;
      logic [4:0]  my;
      logic [23:0] p;
      logic [4:0]  lo;
      logic [2:0]  e;
      logic [3:0]  f;
      logic        s;
      logic [8:0]  r;
      mx = (x[6:4] == 3'd0) ? {1'b0, x[3:0]} : {1'b1, x[3:0]};
      my = (y[6:4] == 3'd0) ? {1'b0, y[3:0]} : {1'b1, y[3:0]};
      p  = (24'(mx) * 24'(my)) << ({1'b0, x[6:4]} + {1'b0, y[6:4]});
      s  = x[7] ^ y[7];
      lo = p[11:7];
      e  = '0;
      f  = '0;
      // Leading-one search over p[18:12]; fraction is the 4 bits below it.
      if (p[18]) begin
         e = 3'd7; f = p[17:14];
      end else if (p[17]) begin
         e = 3'd6; f = p[16:13];
      end else if (p[16]) begin
         e = 3'd5; f = p[15:12];
      end else if (p[15]) begin
         e = 3'd4; f = p[14:11];
      end else if (p[14]) begin
         e = 3'd3; f = p[13:10];
      end else if (p[13]) begin
         e = 3'd2; f = p[12:9];
      end else if (p[12]) begin
         e = 3'd1; f = p[11:8];
      end else begin
         e = 3'd0; f = (lo > 5'd15) ? 4'hF : lo[3:0];
      end
      if (|p[23:19]) begin
         r = {1'b1, s, 7'h7F};
      end else if ({e, f} == 7'd0) begin
         r = '0;
      end else begin
         r = {1'b0, s, e, f};
      end
      return r;
   endfunction

   // Sum of two mini-floats (sign-magnitude); bit 8 flags saturation.
   function automatic logic [8:0] fp_add(input logic [7:0] x, input logic [7:0] y);
      logic [4:0]  mx;
      logic [4:0]  my;
      logic [12:0] sx;
      logic [12:0] sy;
      logic [12:0] sm;
      logic        sg;
      logic [2:0]  e;
      logic [3:0]  f;
      logic [8:0]  r;
      mx = (x[6:4] == 3'd0) ? {1'b0, x[3:0]} : {1'b1, x[3:0]};
      my = (y[6:4] == 3'd0) ? {1'b0, y[3:0]} : {1'b1, y[3:0]};
      sx = 13'(mx) << x[6:4];
      sy = 13'(my) << y[6:4];
      if (x[7] == y[7]) begin
         sm = sx + sy; sg = x[7];
      end else if (sx >= sy) begin
         sm = sx - sy; sg = x[7];
      end else begin
         sm = sy - sx; sg = y[7];
      end
      e = '0;
      f = '0;
      if (sm[11]) begin
         e = 3'd7; f = sm[10:7];
      end else if (sm[10]) begin
         e = 3'd6; f = sm[9:6];
      end else if (sm[9]) begin
         e = 3'd5; f = sm[8:5];
      end else if (sm[8]) begin
         e = 3'd4; f = sm[7:4];
      end else if (sm[7]) begin
         e = 3'd3; f = sm[6:3];
      end else if (sm[6]) begin
         e = 3'd2; f = sm[5:2];
      end else if (sm[5]) begin
         e = 3'd1; f = sm[4:1];
      end else begin
         e = 3'd0; f = (sm > 13'd15) ? 4'hF : sm[3:0];
      end
      if (sm[12]) begin
         r = {1'b1, sg, 7'h7F};
      end else if ({e, f} == 7'd0) begin
         r = '0;
      end else begin
         r = {1'b0, sg, e, f};
      end
      return r;
   endfunction

   // Wavefront step: cell (i,j) is active only when t = i+j+k for some k.
   always_comb begin
      logic [8:0] pr;
      logic [8:0] sm;
      pr      = '0;
      sm      = '0;
      sat_any = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         for (int unsigned j = 0; j < N; j++) begin
            c_nxt[i][j] = c_q[i][j];
            for (int unsigned k = 0; k < N; k++) begin
               if (32'(t_q) == i + j + k) begin
                  pr          = fp_mul(a_q[i][k], b_q[k][j]);
                  sm          = fp_add(c_q[i][j], pr[7:0]);
                  c_nxt[i][j] = sm[7:0];
                  sat_any     = sat_any | pr[8] | sm[8];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         t_q    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         ovf_q  <= 1'b0;
         for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
               a_q[i][j] <= '0;
               b_q[i][j] <= '0;
               c_q[i][j] <= '0;
            end
         end
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  for (int unsigned i = 0; i < N; i++) begin
                     for (int unsigned j = 0; j < N; j++) begin
                        a_q[i][j] <= bus.a_flat[(i*N+j)*8 +: 8];
                        b_q[i][j] <= bus.b_flat[(i*N+j)*8 +: 8];
                        if (!bus.accumulate) begin
                           c_q[i][j] <= '0;
                        end
                     end
                  end
                  ovf_q  <= 1'b0;
                  t_q    <= '0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               for (int unsigned i = 0; i < N; i++) begin
                  for (int unsigned j = 0; j < N; j++) begin
                     c_q[i][j] <= c_nxt[i][j];
                  end
               end
               if (sat_any) begin
                  ovf_q <= 1'b1;
               end
               if (t_q == LAST) begin
                  busy_q <= 1'b0;
                  state  <= DONE;
               end else begin
                  t_q <= t_q + 1'b1;
               end
            end
            DONE: begin
               // done is registered on leaving DONE, so it is seen in the
               // cycle after the DONE state.
               done_q <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus.c_flat = '0;
      for (int unsigned i = 0; i < N; i++) begin
         for (int unsigned j = 0; j < N; j++) begin
            bus.c_flat[(i*N+j)*8 +: 8] = c_q[i][j];
         end
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_matmul_engine.sv
// tb_matmul_engine
//   Drives three engines (N = 3, 2, 8) sharing clk/reset and checks them
//   against a value-level model of the mini-float arithmetic.
module tb_matmul_engine;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic         st     [3];
   logic         acc;
   logic [7:0]   ma     [8][8];
   logic [7:0]   mb     [8][8];
   logic [511:0] c_o    [3];
   logic         busy_o [3];
   logic         done_o [3];
   logic         ovf_o  [3];

   logic [7:0] mc      [3][8][8];
   bit         exp_ovf [3];

   int n_checks = 0;
   int n_errors = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned NG = (g == 0) ? 3 : (g == 1) ? 2 : 8;
      matmul_engine_if #(.N(NG)) bus_if ();
      matmul_engine #(.N(NG)) dut (
         .clk   (clk),
         .reset (reset),
         .bus   (bus_if)
      );
      always_comb begin
         bus_if.start      = st[g];
         bus_if.accumulate = acc;
         bus_if.a_flat     = '0;
         bus_if.b_flat     = '0;
         for (int unsigned i = 0; i < NG; i++) begin
            for (int unsigned j = 0; j < NG; j++) begin
               bus_if.a_flat[(i*NG+j)*8 +: 8] = ma[i][j];
               bus_if.b_flat[(i*NG+j)*8 +: 8] = mb[i][j];
            end
         end
      end
      assign c_o[g]    = 512'(bus_if.c_flat);
      assign busy_o[g] = bus_if.busy;
      assign done_o[g] = bus_if.done;
      assign ovf_o[g]  = bus_if.ovf;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int dim(input int id);
      return (id == 0) ? 3 : (id == 1) ? 2 : 8;
   endfunction

   function automatic logic [7:0] c_el(input int id, input int i, input int j);
      logic [511:0] v;
      v = c_o[id];
      return v[(i*dim(id)+j)*8 +: 8];
   endfunction

   // Reference arithmetic: decode to a signed value in 1/128 units, do plain
   // integer arithmetic, re-encode with truncation and saturation.
   function automatic int dec(input logic [7:0] x);
      int m;
      if (x[6:4] == 3'd0) m = int'(x[3:0]);
      else                m = (16 + int'(x[3:0])) << x[6:4];
      return x[7] ? -m : m;
   endfunction

   function automatic logic [8:0] enc(input int mag, input bit neg);
      int e;
      if (mag >= 4096) return {1'b1, neg, 7'h7F};
      if (mag == 0)    return 9'h000;
      if (mag < 32)    return {1'b0, neg, 3'd0, 4'((mag < 15) ? mag : 15)};
      e = 0;
      while ((mag >> e) > 31) e++;
      return {1'b0, neg, 3'(e), 4'((mag >> e) - 16)};
   endfunction

   function automatic logic [8:0] mul_ref(input logic [7:0] a, input logic [7:0] b);
      int p;
      p = dec(a) * dec(b);
      return enc(((p < 0) ? -p : p) / 128, p < 0);
   endfunction

   function automatic logic [8:0] add_ref(input logic [7:0] a, input logic [7:0] b);
      int s;
      s = dec(a) + dec(b);
      return enc((s < 0) ? -s : s, s < 0);
   endfunction

   task automatic model_run(input int id, input bit accv);
      int         n;
      logic [7:0] c;
      logic [8:0] r;
      bit         ov;
      n  = dim(id);
      ov = 1'b0;
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < n; j++) begin
            c = accv ? mc[id][i][j] : 8'h00;
            for (int k = 0; k < n; k++) begin
               r  = mul_ref(ma[i][k], mb[k][j]);
               ov = ov | r[8];
               r  = add_ref(c, r[7:0]);
               ov = ov | r[8];
               c  = r[7:0];
            end
            mc[id][i][j] = c;
         end
      end
      exp_ovf[id] = ov;
   endtask

   task automatic model_reset();
      for (int id = 0; id < 3; id++) begin
         exp_ovf[id] = 1'b0;
         for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
               mc[id][i][j] = 8'h00;
      end
   endtask

   function automatic logic [7:0] rnd_byte();
      if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 255));
      return {1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)), 4'($urandom_range(0, 15))};
   endfunction

   task automatic scramble();
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) begin
            ma[i][j] = rnd_byte();
            mb[i][j] = rnd_byte();
         end
   endtask

   task automatic fill(input logic [7:0] av, input logic [7:0] bv);
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) begin
            ma[i][j] = av;
            mb[i][j] = bv;
         end
   endtask

   task automatic check_c_all(input int id, input string tag);
      for (int i = 0; i < dim(id); i++)
         for (int j = 0; j < dim(id); j++)
            check_val($sformatf("%s_n%0d_c%0d%0d", tag, dim(id), i, j), c_el(id, i, j), mc[id][i][j]);
   endtask

   // One run: operands are scrambled right after the start edge, so the
   // results only match if the engine latched them.
   task automatic run_mm(input int id, input bit accv, input bit poke);
      int n;
      int cnt;
      n = dim(id);
      model_run(id, accv);
      acc    = accv;
      st[id] = 1'b1;
      tick();
      st[id] = 1'b0;
      scramble();
      cnt = 0;
      while (busy_o[id] && cnt < 200) begin
         cnt++;
         if (poke) st[id] = (cnt == 3);
         tick();
      end
      st[id] = 1'b0;
      check_val($sformatf("busy_len_n%0d", n), cnt, 3 * n - 2);
      check_val("done_gap", done_o[id], 1'b0);
      tick();
      check_val("done_pulse", done_o[id], 1'b1);
      tick();
      check_val("done_clear", done_o[id], 1'b0);
      check_val("idle_busy", busy_o[id], 1'b0);
      check_val($sformatf("ovf_n%0d", n), ovf_o[id], exp_ovf[id]);
      check_c_all(id, "run");
   endtask

   task automatic check_reset_state(input string tag);
      for (int id = 0; id < 3; id++) begin
         check_val($sformatf("%s_busy%0d", tag, id), busy_o[id], 1'b0);
         check_val($sformatf("%s_done%0d", tag, id), done_o[id], 1'b0);
         check_val($sformatf("%s_ovf%0d", tag, id), ovf_o[id], 1'b0);
         check_val($sformatf("%s_c%0d", tag, id), 32'(c_o[id] != '0), 32'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int g = 0; g < 3; g++) st[g] = 1'b0;
      acc   = 1'b0;
      fill(8'h00, 8'h00);
      model_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check_reset_state("rst");

      // Outputs hold reset values with inputs moving but no start.
      for (int c = 0; c < 3; c++) begin
         scramble();
         acc = 1'($urandom_range(0, 1));
         tick();
      end
      check_reset_state("hold");

      // Identity: diag 1.0 times all 0x35.
      fill(8'h00, 8'h35);
      for (int i = 0; i < 3; i++) ma[i][i] = 8'h30;
      run_mm(0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            check_val("ident", c_el(0, i, j), 8'h35);

      // Ones, then accumulate on top.
      fill(8'h30, 8'h30);
      run_mm(0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            check_val("ones", c_el(0, i, j), 8'h48);
      fill(8'h30, 8'h30);
      run_mm(0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            check_val("ones_acc", c_el(0, i, j), 8'h58);

      // Saturation and sticky ovf.
      fill(8'h00, 8'h00);
      ma[0][0] = 8'h7F;
      mb[0][0] = 8'h7F;
      run_mm(0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            check_val("sat_c", c_el(0, i, j), (i == 0 && j == 0) ? 8'h7F : 8'h00);
      check_val("sat_ovf", ovf_o[0], 1'b1);
      for (int c = 0; c < 3; c++) tick();
      check_val("sat_ovf_hold", ovf_o[0], 1'b1);

      // Sign and no negative zero; also clears ovf on the new start.
      fill(8'h00, 8'h00);
      for (int i = 0; i < 3; i++) begin
         ma[i][i] = 8'hB0;
         mb[i][i] = 8'h30;
      end
      run_mm(0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            check_val("sign", c_el(0, i, j), (i == j) ? 8'hB0 : 8'h00);
      check_val("sign_ovf_clr", ovf_o[0], 1'b0);

      // Start pulsed mid-run is ignored.
      scramble();
      run_mm(0, 1'($urandom_range(0, 1)), 1'b1);

      // Reset at RUN step 2 aborts with no done pulse.
      scramble();
      acc   = 1'b1;
      st[0] = 1'b1;
      tick();
      st[0] = 1'b0;
      tick();
      tick();
      check_val("pre_rst_busy", busy_o[0], 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
      check_reset_state("abort");
      for (int c = 0; c < 4; c++) begin
         tick();
         check_val("abort_no_done", done_o[0], 1'b0);
      end

      // Reset wins over start in the same cycle.
      st[0] = 1'b1;
      reset = 1'b1;
      tick();
      st[0] = 1'b0;
      reset = 1'b0;
      check_val("rst_over_start", busy_o[0], 1'b0);

      // Random sweep over all three sizes.
      for (int r = 0; r < 6; r++) begin
         scramble();
         run_mm(1, 1'($urandom_range(0, 1)), 1'b0);
      end
      for (int r = 0; r < 4; r++) begin
         scramble();
         run_mm(0, 1'($urandom_range(0, 1)), 1'b0);
      end
      for (int r = 0; r < 3; r++) begin
         scramble();
         run_mm(2, 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/matmul_engine.md
MATMUL_ENGINE -- requirements
Module: matmul_engine

Interface
REQ-001 SHALL have parameter N, default 3, legal 2..8: matrix dimension; C = A x B with N x N operands.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request a multiply; sampled only in IDLE.
REQ-005 SHALL have port accumulate, input, 1 bit: sampled with start; 1 gives C = C + A x B, 0 gives C = A x B.
REQ-006 SHALL have port a_flat, input, N*N*8 bits: matrix A; element (i,j) at bits [(i*N+j)*8 +: 8].
REQ-007 SHALL have port b_flat, input, N*N*8 bits: matrix B, same packing as a_flat.
REQ-008 SHALL have port c_flat, output, N*N*8 bits: registered result C, same packing.
REQ-009 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when C is final.
REQ-011 SHALL have port ovf, output, 1 bit: sticky saturation flag; cleared on accepted start and on reset.

Function
REQ-012 SHALL use the 8-bit number format: s = bit7, E = bits6:4, F = bits3:0; M = F when E = 0, M = 16+F otherwise; magnitude m = M << E in units of 1/128 (0x30 = 1.0).
REQ-013 SHALL implement FSM states IDLE, RUN, DONE: IDLE->RUN on start; RUN->DONE after step 3N-3; DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL on accepted start latch a_flat and b_flat internally; input changes during RUN have no effect.
REQ-015 SHALL on accepted start clear C when accumulate = 0, and keep C when accumulate = 1.
REQ-016 SHALL in RUN step t (0..3N-3) update cell (i,j) when k = t-i-j is in 0..N-1: C[i][j] <= add(C[i][j], mul(A[i][k], B[k][j])); other cells hold.
REQ-017 SHALL use the following latency: start sampled at edge 0; busy = 1 for edges 1..3N-2; done = 1 for the cycle after edge 3N-1; c_flat held stable after that until the next accepted start.
REQ-018 SHALL ignore start in RUN and DONE; no queuing.
REQ-019 SHALL compute mul as follows:
- product P = (Ma*Mb) << (Ea+Eb), 24 bits; sign = sa XOR sb.
- If any bit of P[23:19] is set: magnitude 0x7F, assert ovf.
- Else, with h the highest set bit in P[18:12]: E = h-11, F = P[h-1:h-4] (truncate).
- Else: E = 0, F = min(P>>7, 15).
REQ-020 SHALL compute add as follows:
- Sx = Mx << Ex, 13 bits.
- Equal signs: sum the magnitudes, keep the sign.
- Unequal signs: subtract the smaller magnitude from the larger; result takes the sign of the larger.
- If bit 12 is set: magnitude 0x7F, assert ovf.
- Else, with h the highest set bit in S[11:5]: E = h-4, F = S[h-1:h-4].
- Else: E = 0, F = min(S, 15).
REQ-021 SHALL force any zero-magnitude result (mul or add) to 0x00; the block never produces negative zero.
REQ-022 SHALL use combinational mul/add datapath only between registered operands and registered C; no combinational path from any input to c_flat, busy, done, or ovf.

Reset
REQ-023 SHALL, when reset = 1 at a rising edge, force IDLE, c_flat = 0, busy = 0, done = 0, ovf = 0, and clear the latched operands.
REQ-024 SHALL let reset override start in the same cycle and abort RUN/DONE immediately, with no done pulse.
REQ-025 SHALL hold all outputs at their reset values after reset until the first accepted start.

Verification
REQ-026 SHALL cover identity: N=3, A = diag 0x30, B all 0x35, accumulate = 0 -> c_flat all 0x35, busy for 7 cycles, done pulse on cycle 8, ovf = 0.
REQ-027 SHALL cover ones and accumulate: N=3, A = B = all 0x30, accumulate = 0 -> every C = 0x48; rerun with accumulate = 1 -> every C = 0x58.
REQ-028 SHALL cover saturation: A00 = B00 = 0x7F, all other elements 0x00 -> C00 = 0x7F, other C = 0x00, ovf = 1 until the next start.
REQ-029 SHALL cover sign and zero: A = diag 0xB0, B = diag 0x30 -> diagonal C = 0xB0, off-diagonal C = 0x00 (never 0x80).
REQ-030 SHALL cover control: start pulsed again mid-RUN -> ignored, one done only; reset asserted at RUN step 2 -> next cycle busy = 0, c_flat = 0, no done.
REQ-031 SHALL cover parameter sweep: N = 2 and N = 8 with random operands against a bit-exact model of REQ-019..021 -> results match, and busy lasts 3N-2 cycles.
